mem_stage: RTL and testbench

//  Memory stage of the 5-stage core. Sits between execute and writeback. Consumes the EX/MEM

---
 rtl/mem_stage_pkg.sv | 42 ++++
 rtl/mem_stage_load_align.sv | 21 ++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory stage (pipeline registers, widths, FSM states)
package mem_stage_pkg;

    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_width_e;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} mem_fsm_e;

    typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_MEM = 2'd1, SRC_PC = 2'd2, SRC_CSR = 2'd3} rf_wr_src_e;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] next_pc;
        logic [31:0] csr_out;
        logic        rf_wr_en;
        rf_wr_src_e  rf_wr_src;
        logic        mem_read;
        logic        mem_sign;
        mem_width_e  mem_width;
    } exec_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } reg_meta_t;

    typedef struct packed {
        logic stall;
        logic squash;
    } stage_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] next_pc;
        logic [31:0] csr_out;
        logic [31:0] load_data;
        logic        rf_wr_en;
        rf_wr_src_e  rf_wr_src;
        logic        mem_err;
    } mem_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: extracts the addressed byte/half/word from a read word and sign- or zero-extends it
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  mem_width_e  width_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(rdata_i >> {off_i, 3'b000});
    assign h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign data_o = width_i == BYTE ? {{24{sign_i & b[7]}}, b}
                  : width_i == HALF ? {{16{sign_i & h[15]}}, h}
                  : rdata_i;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load alignment, bounded wait on slow memory, hold buffer and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  exec_state_t exec_state_i,
    input  reg_meta_t   reg_meta_i,
    input  stage_ctrl_t stage_ctrl_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_req_o,
    output logic        fwd_valid_o,
    output logic [4:0]  fwd_rd_o,
    output logic [31:0] fwd_data_o,
    output logic        valid_o,
    output mem_state_t  mem_state_o,
    output reg_meta_t   reg_meta_o
);

    localparam int CW = $clog2(TIMEOUT);

    mem_fsm_e      fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_vld_q, hold_vld_d;
    logic          hold_err_q, hold_err_d;
    logic [31:0]   hold_data_q, hold_data_d;
    logic          valid_q, valid_d;
    mem_state_t    state_q, state_d;
    reg_meta_t     meta_q;

    logic        load, need, last, rv_ok, tmo, resp, avail, upd, ld_err;
    logic [31:0] aligned, ld_data;

    load_align u_align (
        .rdata_i (dmem_rdata_i),
        .off_i   (exec_state_i.alu_out[1:0]),
        .width_i (exec_state_i.mem_width),
        .sign_i  (exec_state_i.mem_sign),
        .data_o  (aligned)
    );

    // need: a live load whose data is not already parked in the hold buffer
    assign load   = valid_i & exec_state_i.mem_read & ~stage_ctrl_i.squash;
    assign need   = load & ~hold_vld_q;
    assign last   = cnt_q == CW'(TIMEOUT - 1);
    assign rv_ok  = need & dmem_rvalid_i & (fsm_q != DRAIN);
    assign tmo    = need & last & ~rv_ok & (fsm_q != IDLE);
    assign resp   = rv_ok | tmo;
    assign avail  = hold_vld_q | resp;
    assign upd    = ~stage_ctrl_i.stall & ~stall_req_o;
    assign ld_data = hold_vld_q ? hold_data_q : tmo ? 32'd0 : aligned;
    assign ld_err  = hold_vld_q ? hold_err_q : tmo;

    assign stall_req_o = load & ~avail;
    assign fwd_rd_o    = reg_meta_i.rd;
    assign fwd_valid_o = valid_i & exec_state_i.rf_wr_en & (reg_meta_i.rd != 5'd0) & (~load | avail);
    assign fwd_data_o  = exec_state_i.rf_wr_src == SRC_MEM ? ld_data
                       : exec_state_i.rf_wr_src == SRC_PC  ? exec_state_i.next_pc
                       : exec_state_i.rf_wr_src == SRC_CSR ? exec_state_i.csr_out
                       : exec_state_i.alu_out;

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = '0;
        case (fsm_q)
            IDLE: fsm_d = need & ~dmem_rvalid_i ? WAIT : IDLE;
            WAIT: begin
                fsm_d = ~need ? (dmem_rvalid_i ? IDLE : DRAIN) : rv_ok ? IDLE : tmo ? DRAIN : WAIT;
                cnt_d = fsm_d == WAIT ? cnt_q + 1'b1 : '0;
            end
            DRAIN: begin
                // first rvalid here belongs to the abandoned request; a waiting load keeps counting
                fsm_d = tmo ? DRAIN : dmem_rvalid_i ? (need ? WAIT : IDLE) : DRAIN;
                cnt_d = need & ~tmo ? cnt_q + 1'b1 : '0;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign hold_vld_d  = ~upd & (hold_vld_q | resp);
    assign hold_data_d = ld_data;
    assign hold_err_d  = ld_err;

    assign valid_d = valid_i & ~stage_ctrl_i.squash;
    assign state_d = '{
        alu_out:   exec_state_i.alu_out,
        next_pc:   exec_state_i.next_pc,
        csr_out:   exec_state_i.csr_out,
        load_data: load ? ld_data : 32'd0,
        rf_wr_en:  exec_state_i.rf_wr_en,
        rf_wr_src: exec_state_i.rf_wr_src,
        mem_err:   load & ld_err
    };

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            hold_vld_q  <= 1'b0;
            hold_err_q  <= 1'b0;
            hold_data_q <= '0;
            valid_q     <= 1'b0;
            state_q     <= '0;
            meta_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            hold_vld_q  <= hold_vld_d;
            hold_err_q  <= hold_err_d;
            hold_data_q <= hold_data_d;
            if (upd) begin
                valid_q <= valid_d;
                state_q <= state_d;
                meta_q  <= reg_meta_i;
            end
        end
    end

    assign valid_o     = valid_q;
    assign mem_state_o = state_q;
    assign reg_meta_o  = meta_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] ld;
        logic        err;
        logic [4:0]  rd;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    exec_state_t exec_state_i = '0;
    reg_meta_t   reg_meta_i = '0;
    stage_ctrl_t stage_ctrl_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_req_o, fwd_valid_o, valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    mem_state_t  mem_state_o;
    reg_meta_t   reg_meta_o;

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .exec_state_i  (exec_state_i),
        .reg_meta_i    (reg_meta_i),
        .stage_ctrl_i  (stage_ctrl_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .stall_req_o   (stall_req_o),
        .fwd_valid_o   (fwd_valid_o),
        .fwd_rd_o      (fwd_rd_o),
        .fwd_data_o    (fwd_data_o),
        .valid_o       (valid_o),
        .mem_state_o   (mem_state_o),
        .reg_meta_o    (reg_meta_o)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_cnt = 0;
    exp_t        exp_q[$];
    logic [31:0] last_pc = '1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        stall_cnt += stall_req_o ? 1 : 0;
        @(posedge clk_i);
        #1;
    endtask

    function automatic exec_state_t mk(logic [31:0] addr, logic [31:0] pc, rf_wr_src_e src,
                                       logic rd_mem, logic sign, mem_width_e w);
        exec_state_t e;
        e = '0;
        e.alu_out   = addr;
        e.next_pc   = pc;
        e.csr_out   = 32'hC5C5_0000 | pc;
        e.rf_wr_en  = 1'b1;
        e.rf_wr_src = src;
        e.mem_read  = rd_mem;
        e.mem_sign  = sign;
        e.mem_width = w;
        return e;
    endfunction

    task automatic issue(exec_state_t e, logic [4:0] rd, logic rv, logic [31:0] rdata);
        valid_i       = 1'b1;
        exec_state_i  = e;
        reg_meta_i    = '{rs1: 5'd1, rs2: 5'd2, rd: rd};
        dmem_rvalid_i = rv;
        dmem_rdata_i  = rdata;
    endtask

    task automatic idle();
        valid_i       = 1'b0;
        dmem_rvalid_i = 1'b0;
        stage_ctrl_i  = '0;
    endtask

    function automatic void expect_entry(exec_state_t e, logic [4:0] rd, logic [31:0] ld, logic err);
        exp_q.push_back('{alu: e.alu_out, pc: e.next_pc, ld: ld, err: err, rd: rd});
    endfunction

    initial begin
        exp_t a, e;
        forever begin
            @(negedge clk_i);
            if (valid_o && mem_state_o.next_pc != last_pc) begin
                last_pc = mem_state_o.next_pc;
                a = '{alu: mem_state_o.alu_out, pc: mem_state_o.next_pc, ld: mem_state_o.load_data,
                      err: mem_state_o.mem_err, rd: reg_meta_o.rd};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected entry: pc=%h ld=%h err=%b", a.pc, a.ld, a.err);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL entry pc=%h: got alu=%h ld=%h err=%b rd=%0d, required pc=%h alu=%h ld=%h err=%b rd=%0d",
                                 a.pc, a.alu, a.ld, a.err, a.rd, e.pc, e.alu, e.ld, e.err, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        exec_state_t e;
        tick();
        tick();
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset mem_state_o", 32'(mem_state_o != '0), 32'd0);
        check("reset stall_req_o", 32'(stall_req_o), 32'd0);
        check("reset fwd_valid_o", 32'(fwd_valid_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        e = mk(32'h0000_1003, 32'h100, SRC_MEM, 1'b1, 1'b1, BYTE);
        issue(e, 5'd5, 1'b1, 32'h80FF_1234);
        expect_entry(e, 5'd5, 32'hFFFF_FF80, 1'b0);
        stall_cnt = 0;
        #1;
        check("lb fwd_valid", 32'(fwd_valid_o), 32'd1);
        check("lb fwd_data", fwd_data_o, 32'hFFFF_FF80);
        tick();
        idle();
        tick();
        check("lb stall cycles", stall_cnt, 0);

        e = mk(32'h0000_2002, 32'h200, SRC_MEM, 1'b1, 1'b0, HALF);
        issue(e, 5'd6, 1'b0, 32'h0);
        expect_entry(e, 5'd6, 32'h0000_BEEF, 1'b0);
        stall_cnt = 0;
        repeat (3) tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hBEEF_0000;
        tick();
        idle();
        tick();
        check("lhu stall cycles", stall_cnt, 3);

        e = mk(32'h0000_3000, 32'h300, SRC_MEM, 1'b1, 1'b0, WORD);
        issue(e, 5'd7, 1'b0, 32'h0);
        expect_entry(e, 5'd7, 32'h0, 1'b1);
        stall_cnt = 0;
        repeat (17) tick();
        check("timeout stall cycles", stall_cnt, 16);
        idle();
        tick();
        e = mk(32'h0000_4000, 32'h400, SRC_MEM, 1'b1, 1'b0, WORD);
        issue(e, 5'd8, 1'b0, 32'h0);
        expect_entry(e, 5'd8, 32'h1234_5678, 1'b0);
        stall_cnt = 0;
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        dmem_rdata_i  = 32'h1234_5678;
        tick();
        idle();
        tick();
        check("drain stall cycles", stall_cnt, 2);

        e = mk(32'h0000_5000, 32'h500, SRC_MEM, 1'b1, 1'b0, WORD);
        issue(e, 5'd9, 1'b0, 32'h0);
        tick();
        tick();
        stage_ctrl_i.squash = 1'b1;
        tick();
        check("squash valid_o", 32'(valid_o), 32'd0);
        idle();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0BAD_0BAD;
        tick();
        check("squash late rvalid valid_o", 32'(valid_o), 32'd0);
        e = mk(32'h0000_6001, 32'h600, SRC_MEM, 1'b1, 1'b0, BYTE);
        issue(e, 5'd10, 1'b1, 32'h0000_A500);
        expect_entry(e, 5'd10, 32'h0000_00A5, 1'b0);
        #1;
        check("post-squash stall_req", 32'(stall_req_o), 32'd0);
        tick();
        idle();
        tick();

        e = mk(32'h0000_7000, 32'h700, SRC_MEM, 1'b1, 1'b0, WORD);
        issue(e, 5'd11, 1'b1, 32'hCAFE_F00D);
        stage_ctrl_i.stall = 1'b1;
        expect_entry(e, 5'd11, 32'hCAFE_F00D, 1'b0);
        tick();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #1;
        check("hold stall_req", 32'(stall_req_o), 32'd0);
        check("hold fwd_data", fwd_data_o, 32'hCAFE_F00D);
        tick();
        stage_ctrl_i.stall = 1'b0;
        tick();
        idle();
        tick();

        e = mk(32'h1234_5678, 32'h800, SRC_ALU, 1'b0, 1'b0, WORD);
        issue(e, 5'd12, 1'b0, 32'h0);
        expect_entry(e, 5'd12, 32'h0, 1'b0);
        #1;
        check("alu fwd_data", fwd_data_o, 32'h1234_5678);
        check("alu stall_req", 32'(stall_req_o), 32'd0);
        tick();
        e = mk(32'h0000_0042, 32'h810, SRC_CSR, 1'b0, 1'b0, WORD);
        issue(e, 5'd0, 1'b0, 32'h0);
        expect_entry(e, 5'd0, 32'h0, 1'b0);
        #1;
        check("csr fwd_data", fwd_data_o, 32'hC5C5_0810);
        check("rd0 fwd_valid", 32'(fwd_valid_o), 32'd0);
        tick();
        idle();
        tick();

        e = mk(32'h0000_9000, 32'h900, SRC_MEM, 1'b1, 1'b0, WORD);
        issue(e, 5'd13, 1'b0, 32'h0);
        tick();
        tick();
        rst_ni = 1'b0;
        idle();
        tick();
        check("mid-wait reset valid_o", 32'(valid_o), 32'd0);
        check("mid-wait reset mem_state_o", 32'(mem_state_o != '0), 32'd0);
        check("mid-wait reset reg_meta_o", 32'(reg_meta_o), 32'd0);
        check("mid-wait reset stall_req", 32'(stall_req_o), 32'd0);
        rst_ni = 1'b1;
        e = mk(32'h0000_A002, 32'hA00, SRC_MEM, 1'b1, 1'b1, HALF);
        issue(e, 5'd14, 1'b1, 32'h8001_0000);
        expect_entry(e, 5'd14, 32'hFFFF_8001, 1'b0);
        #1;
        check("post-reset stall_req", 32'(stall_req_o), 32'd0);
        tick();
        idle();
        tick();
        tick();
        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
